// File: rtl/qdi_pkg.sv
// Shared types and 1of4 code helpers for the QDI SRAM-bank responder.
// A 1of4 group carries one 2-bit value on four rails; all-low is neutral.
package qdi_pkg;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_EXEC,
    S_ACK,
    S_RD_WAIT,
    S_RD_SEND,
    S_RD_NEUT
  } state_e;

  function automatic logic onehot4_valid(input logic [3:0] r);
    return (r != 4'b0) && ((r & (r - 4'b1)) == 4'b0);
  endfunction

  function automatic logic onehot4_illegal(input logic [3:0] r);
    return (r & (r - 4'b1)) != 4'b0;
  endfunction

  function automatic logic [1:0] onehot4_to_bin2(input logic [3:0] r);
    return {r[3] | r[2], r[3] | r[1]};
  endfunction

  function automatic logic [3:0] bin2_to_onehot4(input logic [1:0] b);
    return 4'b0001 << b;
  endfunction

endpackage

// File: rtl/qdi_sync_vec.sv
// Multi-flop synchronizer for a vector of asynchronous rails.
// Each bit is an independent chain; QDI codes tolerate per-rail skew.
module qdi_sync_vec #(
  parameter int W    = 1,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg_q [SYNC];

  // shift every rail through SYNC flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) stg_q[i] <= '0;
    end else begin
      stg_q[0] <= d;
      for (int i = 1; i < SYNC; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign q = stg_q[SYNC-1];

endmodule

// File: rtl/sram_bank_qdi_responder.sv
// Clocked target end of the QDI SRAM-bank channel: 1of2 RW, 1of4 address
// and data in, 1of4 read data out, backed by a cleared word array.
module sram_bank_qdi_responder
  import qdi_pkg::*;
#(
  parameter int AW   = 10,
  parameter int DW   = 4,
  parameter int SYNC = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [2*AW-1:0]   A,
  output logic [AW/2-1:0]   Ae,
  input  logic [1:0]        RW,
  output logic              RWe,
  input  logic [2*DW-1:0]   WriteData,
  output logic [DW/2-1:0]   WriteDataEn,
  output logic [2*DW-1:0]   ReadData,
  input  logic [DW/2-1:0]   ReadDataEn,
  output logic              Ready,
  output logic              ProtoErr
);

  localparam int AG    = AW / 2;
  localparam int DG    = DW / 2;
  localparam int DEPTH = 2 ** AW;

  logic [2*AW-1:0] a_s;
  logic [1:0]      rw_s;
  logic [2*DW-1:0] wd_s;
  logic [DG-1:0]   rde_s;

  qdi_sync_vec #(.W(2*AW), .SYNC(SYNC)) u_sync_a (
    .clk(CLK), .rst_n(RESET), .d(A), .q(a_s)
  );
  qdi_sync_vec #(.W(2), .SYNC(SYNC)) u_sync_rw (
    .clk(CLK), .rst_n(RESET), .d(RW), .q(rw_s)
  );
  qdi_sync_vec #(.W(2*DW), .SYNC(SYNC)) u_sync_wd (
    .clk(CLK), .rst_n(RESET), .d(WriteData), .q(wd_s)
  );
  qdi_sync_vec #(.W(DG), .SYNC(SYNC)) u_sync_rde (
    .clk(CLK), .rst_n(RESET), .d(ReadDataEn), .q(rde_s)
  );

  logic [AG-1:0] a_vld, a_ill;
  logic [AW-1:0] a_bin;
  logic [DG-1:0] wd_vld, wd_ill;
  logic [DW-1:0] wd_bin;

  for (genvar g = 0; g < AG; g++) begin : g_a
    assign a_vld[g]       = onehot4_valid(a_s[4*g +: 4]);
    assign a_ill[g]       = onehot4_illegal(a_s[4*g +: 4]);
    assign a_bin[2*g +: 2] = onehot4_to_bin2(a_s[4*g +: 4]);
  end

  for (genvar g = 0; g < DG; g++) begin : g_wd
    assign wd_vld[g]        = onehot4_valid(wd_s[4*g +: 4]);
    assign wd_ill[g]        = onehot4_illegal(wd_s[4*g +: 4]);
    assign wd_bin[2*g +: 2] = onehot4_to_bin2(wd_s[4*g +: 4]);
  end

  logic rw_vld, rw_ill, rw_wr;
  logic a_all, wd_all;
  logic a_neut, wd_neut, rw_neut;
  logic any_ill;

  assign rw_vld  = rw_s[0] ^ rw_s[1];
  assign rw_ill  = rw_s[0] & rw_s[1];
  assign rw_wr   = rw_s[0];
  assign a_all   = &a_vld;
  assign wd_all  = &wd_vld;
  assign a_neut  = ~|a_s;
  assign wd_neut = ~|wd_s;
  assign rw_neut = ~|rw_s;
  assign any_ill = (|a_ill) | (|wd_ill) | rw_ill;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ae_q, ae_d;
  logic            rwe_q, rwe_d;
  logic            wde_q, wde_d;
  logic [2*DW-1:0] rd_q, rd_d;
  logic            ready_q, ready_d;
  logic            perr_q, perr_d;

  logic [DW-1:0]   mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [DW-1:0]   mem_wd;
  logic [2*DW-1:0] rdata_enc;

  for (genvar g = 0; g < DG; g++) begin : g_rd
    assign rdata_enc[4*g +: 4] = bin2_to_onehot4(rdata_q[2*g +: 2]);
  end

  // next-state, array port and registered handshake outputs
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    ae_d    = ae_q;
    rwe_d   = rwe_q;
    wde_d   = wde_q;
    rd_d    = rd_q;
    ready_d = ready_q;
    perr_d  = perr_q | any_ill;
    mem_we  = 1'b0;
    mem_wa  = addr_q;
    mem_wd  = wdata_q;
    unique case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = ptr_q;
        mem_wd = '0;
        ptr_d  = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (rw_vld && a_all && (!rw_wr || wd_all)) begin
          state_d = S_EXEC;
          addr_d  = a_bin;
          wdata_d = wd_bin;
          wr_d    = rw_wr;
        end
      end
      S_EXEC: begin
        if (wr_q) mem_we = 1'b1;
        else rdata_d = mem[addr_q];
        ae_d    = 1'b0;
        rwe_d   = 1'b0;
        wde_d   = !wr_q;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (rw_neut && a_neut && (!wr_q || wd_neut)) begin
          ae_d    = 1'b1;
          rwe_d   = 1'b1;
          wde_d   = 1'b1;
          state_d = wr_q ? S_IDLE : S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (&rde_s) begin
          rd_d    = rdata_enc;
          state_d = S_RD_SEND;
        end
      end
      S_RD_SEND: begin
        if (~|rde_s) begin
          rd_d    = '0;
          state_d = S_RD_NEUT;
        end
      end
      S_RD_NEUT: begin
        if (&rde_s) state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // control and output registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      ae_q    <= 1'b1;
      rwe_q   <= 1'b1;
      wde_q   <= 1'b1;
      rd_q    <= '0;
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      ae_q    <= ae_d;
      rwe_q   <= rwe_d;
      wde_q   <= wde_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      perr_q  <= perr_d;
    end
  end

  // word array; contents are defined by the post-reset clear sweep
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign Ae          = {AG{ae_q}};
  assign RWe         = rwe_q;
  assign WriteDataEn = {DG{wde_q}};
  assign ReadData    = rd_q;
  assign Ready       = ready_q;
  assign ProtoErr    = perr_q;

endmodule

// File: tb/tb_sram_bank_qdi_responder.sv
// Directed bench for the QDI SRAM-bank responder with a 4-phase initiator
// BFM, a word-level array model and a per-cycle output compare process.
module tb_sram_bank_qdi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [19:0] a = '0;
  logic [1:0]  rw = '0;
  logic [7:0]  wd = '0;
  logic [1:0]  rde = '0;
  logic [4:0]  Ae;
  logic        RWe;
  logic [1:0]  WriteDataEn;
  logic [7:0]  ReadData;
  logic        Ready;
  logic        ProtoErr;

  sram_bank_qdi_responder #(.AW(10), .DW(4), .SYNC(2)) dut (
    .CLK(clk),
    .RESET(rst_n),
    .A(a),
    .Ae(Ae),
    .RW(rw),
    .RWe(RWe),
    .WriteData(wd),
    .WriteDataEn(WriteDataEn),
    .ReadData(ReadData),
    .ReadDataEn(rde),
    .Ready(Ready),
    .ProtoErr(ProtoErr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] mdl_mem [1024];
  bit         mdl_clearing = 1'b1;
  bit         mdl_perr = 1'b0;
  bit         perr_settling = 1'b0;
  logic [7:0] mdl_rd_exp = '0;

  function automatic logic [19:0] enc_addr(input int ad);
    logic [19:0] r;
    r = '0;
    for (int g = 0; g < 5; g++) r[4*g + ((ad >> (2*g)) & 3)] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] enc_data(input int v);
    logic [7:0] r;
    r = '0;
    for (int g = 0; g < 2; g++) r[4*g + ((v >> (2*g)) & 3)] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // outputs against the model every cycle
  always @(negedge clk) begin
    if (mdl_clearing)
      chk("clear_outputs", {15'd0, Ae, RWe, WriteDataEn, ReadData, Ready},
          {15'd0, 5'h1f, 1'b1, 2'b11, 8'h00, 1'b0});
    else
      chk("rd_rails", {31'd0, (ReadData == 8'h00 || ReadData == mdl_rd_exp)},
          32'd1);
    if (!perr_settling) chk("proto_err", {31'd0, ProtoErr}, {31'd0, mdl_perr});
  end

  task automatic wait_en(input logic lvl, input logic wdinc,
                         input string nm);
    int  n;
    logic ok;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      ok = (Ae == {5{lvl}}) && (RWe == lvl) &&
           (!wdinc || WriteDataEn == {2{lvl}});
    end while (!ok && n < 200);
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rd(input logic nz, input string nm);
    int  n;
    logic ok;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      ok = ((ReadData != 8'h00) == nz);
    end while (!ok && n < 200);
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    a = '0; rw = '0; wd = '0; rde = '0;
    mdl_clearing = 1'b1;
    mdl_perr = 1'b0;
    perr_settling = 1'b0;
    mdl_rd_exp = '0;
    for (int i = 0; i < 1024; i++) mdl_mem[i] = 4'h0;
    #1;
    chk("reset_readdata", {24'd0, ReadData}, 32'h0);
    chk("reset_enables", {24'd0, Ae, RWe, WriteDataEn}, 32'hff);
    chk("reset_ready_perr", {30'd0, Ready, ProtoErr}, 32'h0);
    #1000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1023) @(posedge clk);
    #1;
    chk("ready_at_1023", {31'd0, Ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("ready_at_1024", {31'd0, Ready}, 32'd1);
    mdl_clearing = 1'b0;
  endtask

  task automatic do_read(input int ad, input logic [7:0] lit);
    logic [7:0] got;
    mdl_rd_exp = enc_data(int'(mdl_mem[ad]));
    a = enc_addr(ad);
    rw = 2'b10;
    wait_en(1'b0, 1'b0, "rd_ack");
    chk("rd_wde_held", {30'd0, WriteDataEn}, 32'h3);
    a = '0;
    rw = '0;
    wait_en(1'b1, 1'b0, "rd_release");
    rde = 2'b11;
    wait_rd(1'b1, "rd_data_up");
    got = ReadData;
    chk("rd_model", {24'd0, got}, {24'd0, mdl_rd_exp});
    chk("rd_literal", {24'd0, got}, {24'd0, lit});
    rde = 2'b00;
    wait_rd(1'b0, "rd_data_down");
    rde = 2'b11;
    repeat (6) @(posedge clk);
    #1;
    mdl_rd_exp = '0;
  endtask

  task automatic do_write(input int ad, input int v);
    a = enc_addr(ad);
    wd = enc_data(v);
    rw = 2'b01;
    wait_en(1'b0, 1'b1, "wr_ack");
    a = '0;
    wd = '0;
    rw = '0;
    wait_en(1'b1, 1'b1, "wr_release");
    mdl_mem[ad] = v[3:0];
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    do_read(0, 8'h11);
    do_write(0, 15);
    do_read(0, 8'h88);
    do_write(10'h3ff, 0);
    do_read(10'h3ff, 8'h11);
    do_read(0, 8'h88);
    do_write(10'h155, 6);
    do_read(10'h155, 8'h24);
    do_write(10'h0ab, 9);
    do_read(10'h0ab, 8'h42);

    perr_settling = 1'b1;
    mdl_rd_exp = enc_data(int'(mdl_mem[0]));
    a = 20'h11113;
    rw = 2'b10;
    repeat (10) @(negedge clk);
    chk("illegal_no_ack", {26'd0, Ae, RWe}, 32'h3f);
    chk("illegal_perr", {31'd0, ProtoErr}, 32'd1);
    mdl_perr = 1'b1;
    perr_settling = 1'b0;
    do_read(0, 8'h88);

    mdl_rd_exp = enc_data(int'(mdl_mem[0]));
    a = enc_addr(0);
    rw = 2'b10;
    wait_en(1'b0, 1'b0, "rs_ack");
    a = '0;
    rw = '0;
    wait_en(1'b1, 1'b0, "rs_release");
    rde = 2'b11;
    wait_rd(1'b1, "rs_data_up");
    chk("rs_data", {24'd0, ReadData}, 32'h88);
    do_reset();
    do_read(0, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
